uart_rx_fifo: RTL

//  UART receiver front-end for the vargen SoC: samples rx_uart, deframes 8N1 bytes and buffers them in a FIFO.

---
 rtl/uart_rx_fifo_pkg.sv | 27 ++
 rtl/uart_rx_fifo_if.sv | 53 +++++
 rtl/uart_rx_fifo_sync_fifo.sv | 70 +++++++
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
//   Shared definitions for the UART receive path: default clock and line
//   rate, default FIFO depth, receiver FSM state encoding and the
//   clocks-per-bit helper.
//   Optional feature macro: UART_PARITY_EN (adds the PARITY state, 8E1).
package uart_rx_fifo_pkg;

  localparam int DEF_CLK_HZ = 16_000_000;
  localparam int DEF_BAUD   = 115_200;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

  // Truncating divide: the bit period is rounded down to whole clocks.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   CPU-side bus of the UART receiver.
//   master : CPU / bus bridge (drives rd_en, clr_err)
//   slave  : uart_rx_fifo    (drives data, status and irq)
//   Signals:
//     rd_en      pop strobe
//     clr_err    clear sticky error flags
//     rd_data    FIFO head, first-word-fall-through
//     rx_empty   FIFO holds no bytes
//     rx_full    FIFO holds DEPTH bytes
//     rx_count   bytes held
//     frame_err  sticky, stop bit sampled low
//     overrun    sticky, byte lost to a full FIFO
//     irq_rx     level, FIFO not empty
//     parity_err sticky, even-parity mismatch (only with UART_PARITY_EN)
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          rd_en;
  logic          clr_err;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic          rx_full;
  logic [CW-1:0] rx_count;
  logic          frame_err;
  logic          overrun;
  logic          irq_rx;
`ifdef UART_PARITY_EN
  logic          parity_err;
`endif

  modport master (
    output rd_en, clr_err,
    input  rd_data, rx_empty, rx_full, rx_count, frame_err, overrun, irq_rx
`ifdef UART_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rx_empty, rx_full, rx_count, frame_err, overrun, irq_rx
`ifdef UART_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     wr_en       push request; accepted when not full or when popped same cycle
//     wr_data     byte to push
//     rd_en       pop request; ignored when empty
//     rd_data     head entry, zero while empty
//     empty/full  occupancy flags
//     count       entries held
//     overflow    push rejected this cycle (full and no pop)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  // A pop frees the slot the simultaneous push needs, so full+pop still writes.
  assign wr_ok    = wr_en && (!full || rd_en);
  assign rd_ok    = rd_en && !empty;
  assign overflow = wr_en && full && !rd_en;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; the empty mask on rd_data covers the
  // reset-state output, and resetting the array would force flops instead of RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver front-end: synchronises rx_uart, deframes 8N1 bytes
//   (8E1 when UART_PARITY_EN is defined) and buffers them in sync_fifo.
//   Ports:
//     clk      system clock, rising edge
//     reset    asynchronous, active-high
//     rx_uart  serial line, idle high, asynchronous to clk
//     bus      uart_rx_fifo_if.slave: rd_en, clr_err in; rd_data, rx_empty,
//              rx_full, rx_count, frame_err, overrun, irq_rx (parity_err) out
//   Parameters: CLK_HZ, BAUD (clocks per bit truncated), DEPTH (power of two, >= 2)
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD   = DEF_BAUD,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_uart,
  uart_rx_fifo_if.slave  bus
);

  localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int BW   = $clog2(CPB + 1);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CPB - 1);

  rx_state_t     state, state_nx;
  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          rx_prev;
  logic          rx_fall;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          half_tick;
  logic          bit_tick;
  logic          baud_clr;
  logic          bit_shift;
  logic          push;
  logic          frame_set;
  logic          fifo_drop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rd_data;
  logic          frame_err_q;
  logic          overrun_q;
`ifdef UART_PARITY_EN
  logic          parity_set;
  logic          parity_bad;
  logic          parity_err_q;
`endif

  // Two-flop synchroniser; idle-high reset value so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_uart};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_s      = rx_sync[1];
  assign rx_fall   = rx_prev && !rx_s;
  assign half_tick = (baud_cnt == HALF_LAST);
  assign bit_tick  = (baud_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    baud_clr  = 1'b0;
    bit_shift = 1'b0;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_PARITY_EN
    parity_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_nx = START;
          baud_clr = 1'b1;
        end
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (half_tick) begin
          baud_clr = 1'b1;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          baud_clr  = 1'b1;
          bit_shift = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          baud_clr   = 1'b1;
          // Even parity: data plus parity bit must hold an even number of ones.
          parity_set = ^{shift_reg, rx_s};
          state_nx   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          baud_clr = 1'b1;
          state_nx = IDLE;
          if (!rx_s) frame_set = 1'b1;
`ifdef UART_PARITY_EN
          else if (!parity_bad) push = 1'b1;
`else
          else push = 1'b1;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      if (baud_clr || state == IDLE) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + BW'(1);
      if (state == START)  bit_cnt <= '0;
      else if (bit_shift)  bit_cnt <= bit_cnt + 3'd1;
      // LSB arrives first, so shift in from the top.
      if (bit_shift) shift_reg <= {rx_s, shift_reg[7:1]};
`ifdef UART_PARITY_EN
      if (state == START)  parity_bad <= 1'b0;
      else if (parity_set) parity_bad <= 1'b1;
`endif
    end
  end

  // Sticky error flags: a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (frame_set)        frame_err_q <= 1'b1;
      else if (bus.clr_err) frame_err_q <= 1'b0;
      if (fifo_drop)        overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
`ifdef UART_PARITY_EN
      if (parity_set)       parity_err_q <= 1'b1;
      else if (bus.clr_err) parity_err_q <= 1'b0;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (shift_reg),
    .rd_en    (bus.rd_en),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .overflow (fifo_drop)
  );

  assign bus.rd_data   = fifo_rd_data;
  assign bus.rx_empty  = fifo_empty;
  assign bus.rx_full   = fifo_full;
  assign bus.rx_count  = fifo_count;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.irq_rx    = !fifo_empty;
`ifdef UART_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
